dmem_arbiter: RTL and testbench

Arbiter and sequencer for the single-ported data RAM behind the memory-access stage. It shares the RAM between the pipeline's load/store path and a debug/loader port. It issues one access at a time through a three-state FSM and returns read data one cycle after issue. It drives the memory-access stage's ready_go, so the pipeline stalls while the debug port owns the RAM.

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data RAM between the memory-access stage and a debug/loader port.
// One access in flight at a time: issue in IDLE, complete (ready/done + read data) one cycle later.
module dmem_arbiter #(
    parameter int          ADDR_W    = 32,
    parameter logic [9:0]  DBG_FUNCT = 10'b0000000_010
) (
    input  logic              clk,
    input  logic              rst,
    // pipeline requester
    input  logic              m_req,
    input  logic              m_wen,
    input  logic [9:0]        m_funct,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_wdata,
    output logic              m_ready,
    output logic [31:0]       m_rdata,
    // debug requester
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    // RAM side
    output logic              ram_r_en,
    output logic              ram_w_en,
    output logic [9:0]        ram_funct,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        M_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;   // 0 = pipeline granted last, 1 = debug
    logic   op_wen_q, op_wen_d;       // direction of the access in flight
    logic   rst_q;                    // keeps the first post-reset cycle quiet
    logic   gnt_m, gnt_d;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            op_wen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            op_wen_q   <= op_wen_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        op_wen_d   = op_wen_q;
        gnt_m      = 1'b0;
        gnt_d      = 1'b0;
        m_ready    = 1'b0;
        m_rdata    = '0;
        d_done     = 1'b0;
        d_rdata    = '0;
        ram_r_en   = 1'b0;
        ram_w_en   = 1'b0;
        ram_funct  = '0;
        ram_addr   = '0;
        ram_wdata  = '0;

        // Reset masks everything, including a completion that was in flight.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (!rst_q) begin
                        // Round-robin on a tie: whoever did not win last time goes first.
                        gnt_m = m_req & (~d_req | last_gnt_q);
                        gnt_d = d_req & ~gnt_m;
                        if (gnt_m) begin
                            ram_r_en   = ~m_wen;
                            ram_w_en   = m_wen;
                            ram_funct  = m_funct;
                            ram_addr   = m_addr;
                            ram_wdata  = m_wdata;
                            op_wen_d   = m_wen;
                            last_gnt_d = 1'b0;
                            state_d    = M_ACC;
                        end else if (gnt_d) begin
                            ram_r_en   = ~d_wen;
                            ram_w_en   = d_wen;
                            ram_funct  = DBG_FUNCT;
                            ram_addr   = d_addr;
                            ram_wdata  = d_wdata;
                            op_wen_d   = d_wen;
                            last_gnt_d = 1'b1;
                            state_d    = D_ACC;
                        end
                    end
                end
                M_ACC: begin
                    m_ready = 1'b1;
                    m_rdata = op_wen_q ? 32'h0 : ram_rdata;
                    state_d = IDLE;
                end
                D_ACC: begin
                    d_done  = 1'b1;
                    d_rdata = op_wen_q ? 32'h0 : ram_rdata;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: bench-side RAM, ownership/golden-memory model checked every cycle,
// directed scenarios with literal expectations, then a long random two-requester run.
module tb_dmem_arbiter;
    localparam int         AW   = 32;
    localparam logic [9:0] DBGF = 10'b0000000_010;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_req, m_wen, d_req, d_wen;
    logic [9:0]    m_funct;
    logic [AW-1:0] m_addr, d_addr;
    logic [31:0]   m_wdata, d_wdata;
    logic          m_ready, d_done;
    logic [31:0]   m_rdata, d_rdata;
    logic          ram_r_en, ram_w_en;
    logic [9:0]    ram_funct;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = 32'h0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DBG_FUNCT(DBGF)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_wen(m_wen), .m_funct(m_funct), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .ram_r_en(ram_r_en), .ram_w_en(ram_w_en), .ram_funct(ram_funct),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Word RAM with registered read, addressed by bits [11:2].
    logic [31:0] ram  [0:1023];
    logic [31:0] gold [0:1023];

    always @(posedge clk) begin
        if (ram_w_en) ram[ram_addr[11:2]] <= ram_wdata;
        if (ram_r_en) ram_rdata <= ram[ram_addr[11:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the RAM, what the pending access returns, who wins the next tie.
    bit          on = 1'b0;
    int          owner = 0;     // 0 none, 1 pipeline, 2 debug
    int          win;
    bit          pref_m = 1'b1;
    bit          quiet = 1'b1;
    logic        o_wen;
    logic [31:0] o_rd;
    logic        e_mr, e_dd, e_re, e_we;
    logic [31:0] e_mrd, e_drd, e_addr, e_wd;
    logic [9:0]  e_fn;

    always @(negedge clk) begin
        if (rst) on = 1'b1;
        if (on) begin
            e_mr = 0; e_dd = 0; e_re = 0; e_we = 0;
            e_mrd = 0; e_drd = 0; e_addr = 0; e_wd = 0; e_fn = 0;
            win = 0;
            if (!rst) begin
                if (owner == 1) begin
                    e_mr = 1; e_mrd = o_wen ? 32'h0 : o_rd;
                end else if (owner == 2) begin
                    e_dd = 1; e_drd = o_wen ? 32'h0 : o_rd;
                end else if (!quiet) begin
                    if (m_req && (!d_req || pref_m)) win = 1;
                    else if (d_req) win = 2;
                    if (win == 1) begin
                        e_re = !m_wen; e_we = m_wen; e_addr = m_addr; e_wd = m_wdata; e_fn = m_funct;
                    end else if (win == 2) begin
                        e_re = !d_wen; e_we = d_wen; e_addr = d_addr; e_wd = d_wdata; e_fn = DBGF;
                    end
                end
            end
            chk("m_ready",   32'(m_ready),   32'(e_mr));
            chk("m_rdata",   m_rdata,        e_mrd);
            chk("d_done",    32'(d_done),    32'(e_dd));
            chk("d_rdata",   d_rdata,        e_drd);
            chk("ram_r_en",  32'(ram_r_en),  32'(e_re));
            chk("ram_w_en",  32'(ram_w_en),  32'(e_we));
            chk("ram_addr",  ram_addr,       e_addr);
            chk("ram_wdata", ram_wdata,      e_wd);
            chk("ram_funct", 32'(ram_funct), 32'(e_fn));
            if (rst) begin
                owner = 0; pref_m = 1'b1; quiet = 1'b1;
            end else begin
                quiet = 1'b0;
                if (owner != 0) owner = 0;
                else if (win == 1) begin
                    owner = 1; o_wen = m_wen; o_rd = gold[m_addr[11:2]]; pref_m = 1'b0;
                    if (m_wen) gold[m_addr[11:2]] = m_wdata;
                end else if (win == 2) begin
                    owner = 2; o_wen = d_wen; o_rd = gold[d_addr[11:2]]; pref_m = 1'b1;
                    if (d_wen) gold[d_addr[11:2]] = d_wdata;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mset(input logic rq, input logic wn, input logic [31:0] a, input logic [31:0] wd);
        m_req = rq; m_wen = wn; m_addr = a; m_wdata = wd; m_funct = 10'h2;
    endtask

    task automatic dset(input logic rq, input logic wn, input logic [31:0] a, input logic [31:0] wd);
        d_req = rq; d_wen = wn; d_addr = a; d_wdata = wd;
    endtask

    int  mw, dw;
    bit  mdn, ddn;

    initial begin
        for (int i = 0; i < 1024; i++) begin ram[i] = 32'h0; gold[i] = 32'h0; end
        ram[32'h100 >> 2]  = 32'hDEADBEEF;
        gold[32'h100 >> 2] = 32'hDEADBEEF;
        rst = 1'b1;
        mset(0, 0, 0, 0);
        dset(0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_quiet", 32'(m_ready | d_done | ram_r_en | ram_w_en), 32'd0);

        // Pipeline load alone
        tick(); mset(1, 0, 32'h100, 0);
        @(negedge clk); chk("ld_ren", 32'(ram_r_en), 32'd1); chk("ld_addr", ram_addr, 32'h100);
        tick();
        @(negedge clk); chk("ld_ready", 32'(m_ready), 32'd1); chk("ld_data", m_rdata, 32'hDEADBEEF);
        tick(); mset(0, 0, 0, 0);
        @(negedge clk); chk("ld_idle", 32'(m_ready | ram_r_en), 32'd0);

        // Store then load of the same word
        tick(); mset(1, 1, 32'h40, 32'h12345678);
        @(negedge clk); chk("st_wen", 32'(ram_w_en), 32'd1);
        tick();
        @(negedge clk); chk("st_ready", 32'(m_ready), 32'd1); chk("st_rdata0", m_rdata, 32'h0);
        tick(); mset(1, 0, 32'h40, 0);
        @(negedge clk); chk("ld2_ren", 32'(ram_r_en), 32'd1);
        tick();
        @(negedge clk); chk("ld2_data", m_rdata, 32'h12345678);
        tick(); mset(0, 0, 0, 0);

        // Debug write then read
        dset(1, 1, 32'h200, 32'hA5A5A5A5);
        @(negedge clk); chk("dw_funct", 32'(ram_funct), 32'(DBGF)); chk("dw_wen", 32'(ram_w_en), 32'd1);
        tick();
        @(negedge clk); chk("dw_done", 32'(d_done), 32'd1);
        tick(); dset(1, 0, 32'h200, 0);
        @(negedge clk); chk("dr_funct", 32'(ram_funct), 32'(DBGF)); chk("dr_ren", 32'(ram_r_en), 32'd1);
        tick();
        @(negedge clk); chk("dr_done", 32'(d_done), 32'd1); chk("dr_data", d_rdata, 32'hA5A5A5A5);
        tick(); dset(0, 0, 0, 0);

        // Reset, then both requesting continuously: M, D, M, D
        rst = 1'b1; tick(); rst = 1'b0; tick();
        mset(1, 0, 32'h100, 0);
        dset(1, 0, 32'h200, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_m_ready", 32'(m_ready), 32'((k % 4) == 1));
            chk("rr_d_done",  32'(d_done),  32'((k % 4) == 3));
            tick();
        end
        mset(0, 0, 0, 0); dset(0, 0, 0, 0);

        // Reset during the completion cycle of a load
        tick(); mset(1, 0, 32'h100, 0);
        @(negedge clk);
        tick(); rst = 1'b1; mset(0, 0, 0, 0);
        @(negedge clk); chk("rst_mid_ready", 32'(m_ready), 32'd0);
        tick(); rst = 1'b0;
        @(negedge clk); chk("rst_mid_quiet", 32'(ram_r_en | m_ready), 32'd0);
        tick(); mset(1, 0, 32'h100, 0); dset(1, 0, 32'h200, 0);
        @(negedge clk); chk("rst_tie_pipe", ram_addr, 32'h100);
        tick();
        @(negedge clk); chk("rst_tie_ready", 32'(m_ready), 32'd1);
        tick(); mset(0, 0, 0, 0);
        @(negedge clk); chk("rst_tie_dbg", ram_addr, 32'h200);
        tick();
        @(negedge clk); chk("rst_tie_done", d_rdata, 32'hA5A5A5A5);
        tick(); dset(0, 0, 0, 0);

        // Random two-requester traffic; every request must finish within 4 cycles
        mw = 0; dw = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            mdn = m_ready; ddn = d_done;
            if (m_req) mw++;
            if (d_req) dw++;
            if (mdn || mw > 6) begin
                n_chk++;
                if (mw > 4) begin n_err++; $display("FAIL m_latency: got %0d cycles, required <= 4", mw); end
            end
            if (ddn || dw > 6) begin
                n_chk++;
                if (dw > 4) begin n_err++; $display("FAIL d_latency: got %0d cycles, required <= 4", dw); end
            end
            tick();
            if (m_req && (mdn || mw > 6)) begin m_req = 1'b0; mw = 0; end
            if (d_req && (ddn || dw > 6)) begin d_req = 1'b0; dw = 0; end
            if (!m_req && $urandom_range(0, 2) != 0) begin
                mset(1, 1'($urandom_range(0, 1)), {20'h0, 6'($urandom_range(0, 63)), 6'h0} >> 2 << 2, $urandom);
                m_funct = 10'($urandom);
            end
            if (!d_req && $urandom_range(0, 2) != 0)
                dset(1, 1'($urandom_range(0, 1)), {20'h0, 6'($urandom_range(0, 63)), 6'h0} >> 2 << 2, $urandom);
        end
        mset(0, 0, 0, 0); dset(0, 0, 0, 0);
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
